lnvd_delay_scheduler: RTL and testbench
=======================================

Name: lnvd_delay_scheduler

Overview:
- Sequencer and arbiter for the LNVD 4-channel, 12-bit sample delay datapath.
- On each incoming 250 kHz sample frame, it time-multiplexes one shared single-port sample RAM across the 4 channels: it writes the 4 new samples, then reads one delayed sample per channel using a programmable per-channel delay.
- It emits one aligned 4-channel output frame per input frame. The block sits between the ADC capture logic and the downstream beam/sum stage.

Parameters:
- ADDR_W, 8, per-channel ring depth is 2^ADDR_W samples; the delay range is 0..2^ADDR_W-1 samples.
- DATA_W, 12, sample width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; data_in1..4 are valid this cycle.
- data_in1..data_in4  in  DATA_W each  channel samples.
- cfg_we  in  1  delay register write strobe.
- cfg_ch  in  2  channel select for cfg_we (0..3 = channels 1..4).
- cfg_delay  in  ADDR_W  delay in samples.
- mem_addr  out  ADDR_W+2  RAM address = {ch[1:0], ptr}.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after the read address is presented.
- data_out1..data_out4  out  DATA_W each  delayed samples, held between frames.
- out_valid  out  1  one-cycle strobe marking a new output frame.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky flag; set when sample_valid arrives while busy.

Behaviour:
- Reset (async, rst=1): state=IDLE; wr_ptr=0; fill=0; all active and shadow delays=0; data_out1..4=0; out_valid=0; overrun=0; mem_we=0; mem_addr=0; mem_wdata=0.
- States: IDLE, WR (4 cycles, ch 0..3), RD (4 cycles, ch 0..3), LAST (1 cycle), OUT (1 cycle), then back to IDLE.
- IDLE:
  - On sample_valid: latch data_in1..4 into an input holding register.
  - Copy the shadow delays into the active delays.
  - Go to WR with ch=0.
- WR: mem_we=1, mem_addr={ch, wr_ptr}, mem_wdata=held sample[ch]. Advance ch; after ch=3 go to RD with ch=0.
- RD:
  - mem_we=0, mem_addr={ch, wr_ptr - delay[ch]}, subtraction modulo 2^ADDR_W (wrap-around).
  - mem_rdata for channel ch-1 is captured in the same cycle.
  - After ch=3, go to LAST.
- LAST: capture mem_rdata for channel 3, then go to OUT.
- OUT:
  - out_valid=1; data_out1..4 update to the captured values in this cycle.
  - wr_ptr increments (wraps 2^ADDR_W-1 -> 0).
  - fill increments, saturating at 2^ADDR_W-1.
  - Return to IDLE.
- Latency: sample_valid in cycle 0 -> out_valid high in cycle 10. The minimum frame period is 11 cycles.
- Warm-up rule: if delay[ch] > fill (fill = frames completed before the current one), output 0 for that channel instead of RAM contents.
- Delay 0 returns the sample written in the same frame.
- Config rules:
  - cfg_we writes the shadow register for cfg_ch in any state.
  - The new delay takes effect only at the next IDLE->WR transition; there is no mid-frame change.
  - If cfg_we and frame start coincide, the shadow write lands first and is used by that frame.
- Overrun: sample_valid while busy=1 drops that sample; overrun is set and stays set until rst. The in-progress frame completes unaffected.
- A reset asserted mid-frame aborts the frame immediately; no out_valid is issued for it.
- mem_we is never high outside WR.

Test Plan:
- Basic path:
  - Stimulus: reset; all delays 0; sample_valid with data_in1..4=0x111,0x222,0x333,0x444.
  - Required: out_valid exactly 10 cycles later; data_out=0x111,0x222,0x333,0x444; mem_we high for exactly 4 cycles, addrs 0x000,0x100,0x200,0x300.
- Per-channel delay:
  - Stimulus: delays 0,1,2,3; frames n=0..5 with data_inK = 16*n+K.
  - Required at frame 5: data_out1=0x51, data_out2=0x42, data_out3=0x33, data_out4=0x24.
  - Required at frame 1: channel 3 and channel 4 outputs read 0 (warm-up).
- Wrap-around:
  - Stimulus: ADDR_W=8; delay 5 on ch1; run 300 frames.
  - Required: from frame 5 onward, data_out1 of frame n equals the input of frame n-5, including across the wr_ptr 255->0 wrap.
- Config timing:
  - Stimulus: cfg_we for ch2, delay=4, issued while busy in frame 10.
  - Required: frame 10 output uses the old delay; frame 11 uses delay 4.
- Overrun:
  - Stimulus: second sample_valid 3 cycles after the first.
  - Required: overrun=1; only one out_valid; the second frame's data is never written (mem_we count=4).
- Reset mid-frame:
  - Stimulus: assert rst in the RD state.
  - Required: outputs 0 asynchronously; no out_valid; the next frame after release reproduces the basic-path result with mem_addr ptr=0.

Source files
------------

// File: rtl/lnvd_delay_scheduler.sv
// LNVD delay scheduler: per sample frame, writes 4 channel samples into a shared
// single-port ring RAM, then reads one delayed sample per channel back out.
module lnvd_delay_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_ch,
  input  logic [ADDR_W-1:0] cfg_delay,
  output logic [ADDR_W+1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [DATA_W-1:0] data_out4,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_LAST, S_OUT} state_t;

  state_t            r_state;
  logic [1:0]        r_ch;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_fill;
  logic [ADDR_W-1:0] r_shadow [4];
  logic [ADDR_W-1:0] r_active [4];
  logic [DATA_W-1:0] r_hold   [4];
  logic [DATA_W-1:0] r_cap0;
  logic [DATA_W-1:0] r_cap1;
  logic [DATA_W-1:0] r_cap2;

  logic [DATA_W-1:0] w_din        [4];
  logic [ADDR_W-1:0] w_shadow_eff [4];
  logic [ADDR_W-1:0] w_rd_ptr     [4];
  logic [3:0]        w_warm;
  logic [1:0]        w_ch_next;
  logic [1:0]        w_cap_ch;
  logic [DATA_W-1:0] w_rdata;

  assign w_din[0] = data_in1;
  assign w_din[1] = data_in2;
  assign w_din[2] = data_in3;
  assign w_din[3] = data_in4;

  // A shadow write in the same cycle as frame start must be seen by that frame.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      assign w_shadow_eff[gi] = (cfg_we && (cfg_ch == 2'(gi))) ? cfg_delay : r_shadow[gi];
      assign w_rd_ptr[gi]     = r_wr_ptr - r_active[gi];
      assign w_warm[gi]       = (r_active[gi] > r_fill);
    end
  endgenerate

  assign w_ch_next = r_ch + 2'd1;
  // RAM data returned now belongs to the channel addressed one cycle earlier.
  assign w_cap_ch  = (r_state == S_LAST) ? 2'd3 : (r_ch - 2'd1);
  assign w_rdata   = w_warm[w_cap_ch] ? '0 : mem_rdata;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_shadow[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) r_shadow[k] <= w_shadow_eff[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      for (int k = 0; k < 4; k++) begin
        r_active[k] <= '0;
        r_hold[k]   <= '0;
      end
      r_cap0    <= '0;
      r_cap1    <= '0;
      r_cap2    <= '0;
      data_out1 <= '0;
      data_out2 <= '0;
      data_out3 <= '0;
      data_out4 <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sample_valid && (r_state != S_IDLE)) overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (sample_valid) begin
            for (int k = 0; k < 4; k++) begin
              r_hold[k]   <= w_din[k];
              r_active[k] <= w_shadow_eff[k];
            end
            mem_we    <= 1'b1;
            mem_addr  <= {2'd0, r_wr_ptr};
            mem_wdata <= w_din[0];
            r_ch      <= 2'd0;
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          r_ch <= w_ch_next;
          if (r_ch == 2'd3) begin
            mem_we   <= 1'b0;
            mem_addr <= {2'd0, w_rd_ptr[0]};
            r_state  <= S_RD;
          end else begin
            mem_addr  <= {w_ch_next, r_wr_ptr};
            mem_wdata <= r_hold[w_ch_next];
          end
        end
        S_RD: begin
          case (r_ch)
            2'd1:    r_cap0 <= w_rdata;
            2'd2:    r_cap1 <= w_rdata;
            2'd3:    r_cap2 <= w_rdata;
            default: ;
          endcase
          r_ch <= w_ch_next;
          if (r_ch == 2'd3) r_state <= S_LAST;
          else mem_addr <= {w_ch_next, w_rd_ptr[w_ch_next]};
        end
        S_LAST: begin
          data_out1 <= r_cap0;
          data_out2 <= r_cap1;
          data_out3 <= r_cap2;
          data_out4 <= w_rdata;
          out_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
          if (r_fill != '1) r_fill <= r_fill + ADDR_W'(1);
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lnvd_delay_scheduler.sv
// Bench for lnvd_delay_scheduler: external RAM model, frame-level reference model
// checked every cycle, plus directed literal expectations.
module tb_lnvd_delay_scheduler;
  localparam int AW = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] data_in1 = '0, data_in2 = '0, data_in3 = '0, data_in4 = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [AW-1:0] cfg_delay = '0;
  logic [AW+1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] data_out1, data_out2, data_out3, data_out4;
  logic          out_valid, busy, overrun;

  lnvd_delay_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3), .data_out4(data_out4),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  logic [DW-1:0] ram [0:1023];
  initial for (int i = 0; i < 1024; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct packed {
    logic [3:0][DW-1:0] d;
    logic [31:0]        c;
  } obs_t;
  obs_t          obs_q[$];
  logic [AW+1:0] we_log[$];

  // Reference model: frame history per channel, evaluated once per accepted frame.
  initial begin : compare
    logic [AW-1:0]      shadow [4];
    logic [DW-1:0]      hist [4][1024];
    logic [3:0][DW-1:0] held, pend, acc_data, dout;
    int                 n_frames, last_acc, last_due, t, fill, d, wch;
    logic               pend_valid, ov_exp, exp_busy, exp_ov, exp_we;
    logic [AW-1:0]      acc_ptr;
    logic [AW+1:0]      exp_addr;
    n_frames = 0; last_acc = -100; last_due = -100; pend_valid = 1'b0; ov_exp = 1'b0;
    held = '0; pend = '0; acc_data = '0; acc_ptr = '0;
    for (int k = 0; k < 4; k++) shadow[k] = '0;
    forever begin
      @(negedge clk);
      t    = cyc;
      dout = {data_out4, data_out3, data_out2, data_out1};
      if (mem_we) we_log.push_back(mem_addr);
      if (out_valid) obs_q.push_back('{d: dout, c: 32'(t)});
      if (rst) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", 32'(|dout), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        n_frames = 0; last_acc = -100; last_due = -100; pend_valid = 1'b0; ov_exp = 1'b0;
        held = '0;
        for (int k = 0; k < 4; k++) shadow[k] = '0;
      end else begin
        exp_busy = (t > last_acc) && (t <= last_due);
        exp_ov   = pend_valid && (t == last_due);
        if (exp_ov) begin
          held       = pend;
          pend_valid = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        for (int k = 0; k < 4; k++) chk($sformatf("data_out%0d", k + 1), 32'(dout[k]), 32'(held[k]));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("overrun", 32'(overrun), 32'(ov_exp));
        exp_we = (t >= last_acc + 1) && (t <= last_acc + 4);
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
          wch      = t - last_acc - 1;
          exp_addr = {2'(wch), acc_ptr};
          chk("mem_addr_wr", 32'(mem_addr), 32'(exp_addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(acc_data[wch]));
        end
        if (cfg_we) shadow[cfg_ch] = cfg_delay;
        if (sample_valid) begin
          if (exp_busy) ov_exp = 1'b1;
          else begin
            acc_data = {data_in4, data_in3, data_in2, data_in1};
            acc_ptr  = AW'(n_frames);
            fill     = (n_frames > 255) ? 255 : n_frames;
            for (int k = 0; k < 4; k++) begin
              hist[k][n_frames % 1024] = acc_data[k];
              d = int'(shadow[k]);
              pend[k] = (d > fill) ? '0 : hist[k][(n_frames - d) % 1024];
            end
            n_frames++;
            last_acc   = t;
            last_due   = t + 10;
            pend_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input logic [DW-1:0] e);
    sample_valid = 1'b1;
    data_in1 = a; data_in2 = b; data_in3 = c; data_in4 = e;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [AW-1:0] dl);
    cfg_we = 1'b1; cfg_ch = ch; cfg_delay = dl;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic clear_logs();
    obs_q.delete();
    we_log.delete();
  endtask

  task automatic chk_frame(input string nm, input int idx, input int ch, input logic [DW-1:0] exp);
    if (idx < obs_q.size()) chk(nm, 32'(obs_q[idx].d[ch]), 32'(exp));
    else chk({nm, "_missing_frame"}, 32'(obs_q.size()), 32'(idx + 1));
  endtask

  task automatic chk_basic(input string nm, input int t0);
    chk({nm, "_out_valid_count"}, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) chk({nm, "_latency"}, obs_q[0].c - 32'(t0), 32'd10);
    chk_frame({nm, "_out1"}, 0, 0, 12'h111);
    chk_frame({nm, "_out2"}, 0, 1, 12'h222);
    chk_frame({nm, "_out3"}, 0, 2, 12'h333);
    chk_frame({nm, "_out4"}, 0, 3, 12'h444);
    chk({nm, "_mem_we_count"}, 32'(we_log.size()), 32'd4);
    if (we_log.size() == 4) begin
      chk({nm, "_addr0"}, 32'(we_log[0]), 32'h000);
      chk({nm, "_addr1"}, 32'(we_log[1]), 32'h100);
      chk({nm, "_addr2"}, 32'(we_log[2]), 32'h200);
      chk({nm, "_addr3"}, 32'(we_log[3]), 32'h300);
    end
  endtask

  logic [DW-1:0] in1 [300];
  logic [DW-1:0] in4 [300];

  initial begin : stim
    int t0;
    tick(); tick();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Basic path, all delays 0.
    clear_logs();
    t0 = cyc;
    send(12'h111, 12'h222, 12'h333, 12'h444);
    repeat (12) tick();
    chk_basic("basic", t0);

    // Per-channel delays 0..3, then a delay change issued mid-frame 10.
    do_reset();
    cfg(2'd0, 8'd0); cfg(2'd1, 8'd1); cfg(2'd2, 8'd2); cfg(2'd3, 8'd3);
    clear_logs();
    for (int n = 0; n < 10; n++) begin
      send(12'(16*n+1), 12'(16*n+2), 12'(16*n+3), 12'(16*n+4));
      repeat (10) tick();
    end
    send(12'hA1, 12'hA2, 12'hA3, 12'hA4);
    tick(); tick();
    cfg(2'd1, 8'd4);
    repeat (7) tick();
    send(12'hB1, 12'hB2, 12'hB3, 12'hB4);
    repeat (12) tick();
    chk("dly_frame_count", 32'(obs_q.size()), 32'd12);
    chk_frame("dly_f1_out3_warm", 1, 2, 12'h000);
    chk_frame("dly_f1_out4_warm", 1, 3, 12'h000);
    chk_frame("dly_f1_out2", 1, 1, 12'h002);
    chk_frame("dly_f5_out1", 5, 0, 12'h051);
    chk_frame("dly_f5_out2", 5, 1, 12'h042);
    chk_frame("dly_f5_out3", 5, 2, 12'h033);
    chk_frame("dly_f5_out4", 5, 3, 12'h024);
    chk_frame("cfg_f10_old_delay", 10, 1, 12'h092);
    chk_frame("cfg_f11_new_delay", 11, 1, 12'h072);
    chk_frame("cfg_f11_out4", 11, 3, 12'h084);

    // Wrap-around: delay 5 on ch1, maximum delay on ch4, at the minimum frame period.
    do_reset();
    cfg(2'd0, 8'd5);
    cfg(2'd3, 8'd255);
    clear_logs();
    for (int n = 0; n < 300; n++) begin
      in1[n] = 12'($urandom);
      in4[n] = 12'($urandom);
      send(in1[n], 12'($urandom), 12'($urandom), in4[n]);
      repeat (10) tick();
    end
    tick(); tick();
    chk("wrap_frame_count", 32'(obs_q.size()), 32'd300);
    chk_frame("wrap_f4_warm", 4, 0, 12'h000);
    for (int n = 5; n < 300; n++) chk_frame($sformatf("wrap_f%0d_out1", n), n, 0, in1[n-5]);
    chk_frame("wrap_f254_out4_warm", 254, 3, 12'h000);
    chk_frame("wrap_f255_out4", 255, 3, in4[0]);
    chk_frame("wrap_f299_out4", 299, 3, in4[44]);

    // Overrun: second strobe 3 cycles in, then a strobe in the output cycle.
    do_reset();
    clear_logs();
    chk("ovr_initial", 32'(overrun), 32'd0);
    send(12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4);
    tick(); tick();
    send(12'h0B1, 12'h0B2, 12'h0B3, 12'h0B4);
    repeat (8) tick();
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_out_valid_count", 32'(obs_q.size()), 32'd1);
    chk("ovr_mem_we_count", 32'(we_log.size()), 32'd4);
    chk_frame("ovr_out1", 0, 0, 12'h0A1);
    chk_frame("ovr_out4", 0, 3, 12'h0A4);
    clear_logs();
    send(12'h0C1, 12'h0C2, 12'h0C3, 12'h0C4);
    repeat (9) tick();
    send(12'h0D1, 12'h0D2, 12'h0D3, 12'h0D4);
    send(12'h0E1, 12'h0E2, 12'h0E3, 12'h0E4);
    repeat (11) tick();
    chk("ovr_edge_count", 32'(obs_q.size()), 32'd2);
    chk_frame("ovr_edge_f0", 0, 1, 12'h0C2);
    chk_frame("ovr_edge_f1", 1, 2, 12'h0E3);
    chk("ovr_edge_we_count", 32'(we_log.size()), 32'd8);

    // Reset in the RD phase aborts the frame and clears outputs at once.
    send(12'h111, 12'h222, 12'h333, 12'h444);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_data_out1", 32'(data_out1), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    clear_logs();
    tick(); tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("mid_rst_no_out_valid", 32'(obs_q.size()), 32'd0);
    clear_logs();
    t0 = cyc;
    send(12'h111, 12'h222, 12'h333, 12'h444);
    repeat (12) tick();
    chk_basic("after_rst", t0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
